// File: rtl/player_input_hub.sv
// Player control front end: debounced push-buttons merged with PS/2 set-2 keys
// into per-channel level, press and auto-repeating action pulses.
module player_input_hub #(
    parameter int                NCH      = 4,
    parameter int                DEB_CYC  = 1000000,
    parameter int                REP_DLY  = 25000000,
    parameter int                REP_PER  = 5000000,
    parameter logic [NCH*8-1:0]  KEYCODES = {8'h3B, 8'h4B, 8'h1C, 8'h23}
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NCH-1:0]  btn_n,
    input  logic            ps2_done,
    input  logic [7:0]      ps2_data,
    input  logic            kb_clr,
    output logic [NCH-1:0]  level,
    output logic [NCH-1:0]  press,
    output logic [NCH-1:0]  act
);

    localparam int DW      = $clog2(DEB_CYC);
    localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int RW      = $clog2(REP_MAX);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REP_DLY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REP_PER - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kb_state_e;

    kb_state_e       kb_state_q;
    logic [NCH-1:0]  key_held_q;
    logic [NCH-1:0]  key_match;

    logic [NCH-1:0]  sync1_q, sync2_q;
    logic [NCH-1:0]  stable_q, stable_d;
    logic [DW-1:0]   deb_cnt_q [NCH];
    logic [DW-1:0]   deb_cnt_d [NCH];

    logic [NCH-1:0]  level_q, level_d;
    logic [NCH-1:0]  press_q, press_d;
    logic [NCH-1:0]  act_q, act_d;
    logic [NCH-1:0]  tick_d;
    logic [RW-1:0]   rep_cnt_q [NCH];
    logic [RW-1:0]   rep_cnt_d [NCH];

    // Channels whose make code equals the current byte
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            key_match[i] = (KEYCODES[8*i +: 8] == ps2_data);
        end
    end

    // Scancode decoder; kb_clr wins over a coincident strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            kb_state_q <= ST_IDLE;
            key_held_q <= '0;
        end else if (kb_clr) begin
            kb_state_q <= ST_IDLE;
            key_held_q <= '0;
        end else if (ps2_done) begin
            case (kb_state_q)
                ST_IDLE: begin
                    if (ps2_data == 8'hF0) begin
                        kb_state_q <= ST_BRK;
                    end else if (ps2_data == 8'hE0) begin
                        kb_state_q <= ST_EXT;
                    end else begin
                        key_held_q <= key_held_q | key_match;
                    end
                end
                ST_BRK: begin
                    key_held_q <= key_held_q & ~key_match;
                    kb_state_q <= ST_IDLE;
                end
                ST_EXT: begin
                    kb_state_q <= (ps2_data == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: kb_state_q <= ST_IDLE;
                default:    kb_state_q <= ST_IDLE;
            endcase
        end
    end

    // Debounce: the stable state only follows a sample that disagrees for DEB_CYC cycles
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NCH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                stable_d[i]  = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
    end

    // Level/press/repeat; the repeat counter idles while the channel is released
    always_comb begin
        level_d = ~stable_q | key_held_q;
        press_d = level_d & ~level_q;
        tick_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!level_d[i]) begin
                rep_cnt_d[i] = '0;
            end else if (press_d[i]) begin
                rep_cnt_d[i] = REP_FIRST;
            end else if (rep_cnt_q[i] == '0) begin
                tick_d[i]    = 1'b1;
                rep_cnt_d[i] = REP_NEXT;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] - RW'(1);
            end
        end
        act_d = press_d | tick_d;
    end

    // Synchronizers, debounce state, counters and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            level_q  <= '0;
            press_q  <= '0;
            act_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                deb_cnt_q[i] <= '0;
                rep_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            level_q  <= level_d;
            press_q  <= press_d;
            act_q    <= act_d;
            for (int i = 0; i < NCH; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign act   = act_q;

endmodule

// File: tb/tb_player_input_hub.sv
// Directed bench for player_input_hub with short debounce/repeat windows.
module tb_player_input_hub;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rstn;
    logic [NCH-1:0] btn_n;
    logic           ps2_done;
    logic [7:0]     ps2_data;
    logic           kb_clr;
    logic [NCH-1:0] level, press, act;

    int checks = 0;
    int errors = 0;

    player_input_hub #(
        .NCH(4), .DEB_CYC(4), .REP_DLY(10), .REP_PER(3),
        .KEYCODES({8'h3B, 8'h4B, 8'h1C, 8'h23})
    ) dut (
        .clk(clk), .rstn(rstn), .btn_n(btn_n), .ps2_done(ps2_done),
        .ps2_data(ps2_data), .kb_clr(kb_clr),
        .level(level), .press(press), .act(act)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_data = b;
        ps2_done = 1'b1;
        step();
        ps2_done = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; btn_n = 4'hF; ps2_done = 1'b0; ps2_data = 8'h00; kb_clr = 1'b0;
        step(); step(); step();
        checks++; if (level !== 4'h0) begin errors++; $display("FAIL reset_level got %h want 0", level); end
        checks++; if (press !== 4'h0) begin errors++; $display("FAIL reset_press got %h want 0", press); end
        checks++; if (act !== 4'h0) begin errors++; $display("FAIL reset_act got %h want 0", act); end
        // Button held across reset release must still be debounced
        btn_n[0] = 1'b0;
        step(); step();
        rstn = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            step();
            checks++;
            if (level[0] !== (s >= 7)) begin errors++; $display("FAIL held_rst_level s=%0d got %b want %b", s, level[0], (s >= 7)); end
            checks++;
            if (press[0] !== (s == 7)) begin errors++; $display("FAIL held_rst_press s=%0d got %b want %b", s, press[0], (s == 7)); end
        end
        btn_n[0] = 1'b1;
        for (int s = 0; s < 8; s++) step();
        checks++; if (level !== 4'h0) begin errors++; $display("FAIL held_rst_release got %h want 0", level); end
    endtask

    task automatic test_debounce();
        for (int g = 0; g < 3; g++) begin
            btn_n[1] = 1'b0;
            for (int s = 0; s < 2; s++) begin
                step();
                checks++; if (level[1] !== 1'b0 || press[1] !== 1'b0) begin errors++; $display("FAIL glitch_low g=%0d got lv=%b pr=%b want 0 0", g, level[1], press[1]); end
            end
            btn_n[1] = 1'b1;
            for (int s = 0; s < 2; s++) begin
                step();
                checks++; if (level[1] !== 1'b0 || press[1] !== 1'b0) begin errors++; $display("FAIL glitch_high g=%0d got lv=%b pr=%b want 0 0", g, level[1], press[1]); end
            end
        end
        btn_n[1] = 1'b0;
        for (int s = 1; s <= 10; s++) begin
            step();
            checks++; if (level[1] !== (s >= 7)) begin errors++; $display("FAIL deb_level s=%0d got %b want %b", s, level[1], (s >= 7)); end
            checks++; if (press[1] !== (s == 7)) begin errors++; $display("FAIL deb_press s=%0d got %b want %b", s, press[1], (s == 7)); end
        end
        btn_n[1] = 1'b1;
        for (int s = 0; s < 8; s++) step();
        checks++; if (level[1] !== 1'b0) begin errors++; $display("FAIL deb_release got %b want 0", level[1]); end
    endtask

    task automatic test_make_break();
        send(8'h23);
        checks++; if (level[0] !== 1'b0) begin errors++; $display("FAIL mk_latency got %b want 0", level[0]); end
        step();
        checks++; if (level[0] !== 1'b1 || press[0] !== 1'b1) begin errors++; $display("FAIL mk_rise got lv=%b pr=%b want 1 1", level[0], press[0]); end
        send(8'h23);
        checks++; if (level[0] !== 1'b1 || press[0] !== 1'b0) begin errors++; $display("FAIL typematic got lv=%b pr=%b want 1 0", level[0], press[0]); end
        step();
        checks++; if (press[0] !== 1'b0) begin errors++; $display("FAIL typematic2 got %b want 0", press[0]); end
        send(8'hF0);
        send(8'h23);
        checks++; if (level[0] !== 1'b1) begin errors++; $display("FAIL brk_latency got %b want 1", level[0]); end
        step();
        checks++; if (level[0] !== 1'b0 || press[0] !== 1'b0) begin errors++; $display("FAIL brk_fall got lv=%b pr=%b want 0 0", level[0], press[0]); end
    endtask

    task automatic test_repeat();
        logic exp;
        send(8'h1C);
        for (int n = 1; n <= 20; n++) begin
            step();
            exp = (n == 1) || (n >= 11 && ((n - 11) % 3) == 0);
            checks++; if (act[1] !== exp) begin errors++; $display("FAIL rep_act n=%0d got %b want %b", n, act[1], exp); end
        end
        send(8'hF0);
        checks++; if (act[1] !== 1'b0) begin errors++; $display("FAIL rep_rel1 got %b want 0", act[1]); end
        send(8'h1C);
        checks++; if (act[1] !== 1'b0) begin errors++; $display("FAIL rep_rel2 got %b want 0", act[1]); end
        for (int n = 0; n < 6; n++) begin
            step();
            checks++; if (level[1] !== 1'b0 || act[1] !== 1'b0) begin errors++; $display("FAIL rep_idle n=%0d got lv=%b act=%b want 0 0", n, level[1], act[1]); end
        end
    endtask

    task automatic test_extended();
        send(8'hE0); send(8'hF0); send(8'h23); step();
        checks++; if (level[0] !== 1'b0) begin errors++; $display("FAIL ext_brk got %b want 0", level[0]); end
        send(8'hE0); send(8'h23); step();
        checks++; if (level[0] !== 1'b0) begin errors++; $display("FAIL ext_make got %b want 0", level[0]); end
        send(8'h23); step();
        checks++; if (level[0] !== 1'b1 || press[0] !== 1'b1) begin errors++; $display("FAIL ext_after got lv=%b pr=%b want 1 1", level[0], press[0]); end
        send(8'hF0); send(8'h23); step();
        checks++; if (level[0] !== 1'b0) begin errors++; $display("FAIL ext_cleanup got %b want 0", level[0]); end
    endtask

    task automatic test_overlap();
        send(8'h4B); step();
        checks++; if (level[2] !== 1'b1 || press[2] !== 1'b1) begin errors++; $display("FAIL ov_key got lv=%b pr=%b want 1 1", level[2], press[2]); end
        btn_n[2] = 1'b0;
        for (int s = 0; s < 8; s++) begin
            step();
            checks++; if (level[2] !== 1'b1 || press[2] !== 1'b0) begin errors++; $display("FAIL ov_btn s=%0d got lv=%b pr=%b want 1 0", s, level[2], press[2]); end
        end
        send(8'hF0); send(8'h4B);
        for (int s = 0; s < 3; s++) begin
            step();
            checks++; if (level[2] !== 1'b1 || press[2] !== 1'b0) begin errors++; $display("FAIL ov_keyup s=%0d got lv=%b pr=%b want 1 0", s, level[2], press[2]); end
        end
        btn_n[2] = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            step();
            checks++; if (level[2] !== (s < 7) || press[2] !== 1'b0) begin errors++; $display("FAIL ov_btnup s=%0d got lv=%b pr=%b want %b 0", s, level[2], press[2], (s < 7)); end
        end
    endtask

    task automatic test_kb_clr();
        kb_clr = 1'b1; send(8'h3B); kb_clr = 1'b0;
        step();
        checks++; if (level[3] !== 1'b0) begin errors++; $display("FAIL clr_prio got %b want 0", level[3]); end
        send(8'h3B); step();
        checks++; if (level[3] !== 1'b1) begin errors++; $display("FAIL clr_make got %b want 1", level[3]); end
        kb_clr = 1'b1; step(); kb_clr = 1'b0; step();
        checks++; if (level[3] !== 1'b0) begin errors++; $display("FAIL clr_held got %b want 0", level[3]); end
        send(8'hE0);
        kb_clr = 1'b1; step(); kb_clr = 1'b0;
        send(8'h3B); step();
        checks++; if (level[3] !== 1'b1) begin errors++; $display("FAIL clr_idle got %b want 1", level[3]); end
        kb_clr = 1'b1; step(); kb_clr = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        send(8'h1C); send(8'hF0);
        rstn = 1'b0; step(); rstn = 1'b1; step();
        checks++; if (level !== 4'h0) begin errors++; $display("FAIL rst_mid_level got %h want 0", level); end
        send(8'h23); step();
        checks++; if (level !== 4'h1) begin errors++; $display("FAIL rst_mid_make got %h want 1", level); end
        kb_clr = 1'b1; step(); kb_clr = 1'b0; step();
    endtask

    task automatic test_parallel();
        send(8'h23); send(8'h1C); send(8'h4B); send(8'h3B);
        checks++; if (level !== 4'h7) begin errors++; $display("FAIL par_partial got %h want 7", level); end
        step();
        checks++; if (level !== 4'hF || press !== 4'h8) begin errors++; $display("FAIL par_all got lv=%h pr=%h want f 8", level, press); end
        kb_clr = 1'b1; step(); kb_clr = 1'b0; step();
        checks++; if (level !== 4'h0) begin errors++; $display("FAIL par_clear got %h want 0", level); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_make_break();
        test_repeat();
        test_extended();
        test_overlap();
        test_kb_clr();
        test_reset_mid();
        test_parallel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
